// File: rtl/cam_window_capture.sv
// rtl/cam_window_capture.sv - OV7670 byte-pair capture, window crop/decimate, frame buffer write (option: GRAY_OUT_EN)
module cam_window_capture #(
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480,
  parameter int WIN_X0  = 0,
  parameter int WIN_Y0  = 0,
  parameter int WIN_W   = 256,
  parameter int WIN_H   = 256,
  parameter int DECIM   = 1,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              freeze,
  input  logic              err_clr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              busy,
  output logic              err_line,
  output logic              err_frame
);

  localparam int XW = $clog2(FRAME_W + 1);
  localparam int YW = $clog2(FRAME_H + 1);
  localparam logic [XW-1:0] X_LO   = XW'(WIN_X0);
  localparam logic [XW-1:0] X_SPAN = XW'(WIN_W);
  localparam logic [XW-1:0] X_END  = XW'(FRAME_W);
  localparam logic [XW-1:0] X_MASK = XW'(DECIM - 1);
  localparam logic [YW-1:0] Y_LO   = YW'(WIN_Y0);
  localparam logic [YW-1:0] Y_SPAN = YW'(WIN_H);
  localparam logic [YW-1:0] Y_END  = YW'(FRAME_H);
  localparam logic [YW-1:0] Y_MASK = YW'(DECIM - 1);

  typedef enum logic [1:0] {S_SYNC, S_VBLANK, S_FRAME} state_t;
  state_t state, state_nxt;

  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              phase;
  logic [7:0]        hi_byte;
  logic              href_q;
  logic              frozen_q;
  logic              overrun;
  logic [ADDR_W-1:0] addr_cnt;
  logic              s1_en;
  logic [ADDR_W-1:0] s1_addr;
  logic [15:0]       s1_data;
  logic              frame_done_q;
  logic [7:0]        frame_cnt_q;
  logic              err_line_q;
  logic              err_frame_q;

  logic              frame_start;
  logic              frame_end;
  logic              href_rise;
  logic              href_fall;
  logic              line_ok;
  logic              x_over;
  logic              take_byte;
  logic              win_hit;
  logic [XW:0]       x_rel;
  logic [YW:0]       y_rel;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_SYNC;
    else        state <= state_nxt;
  end

  // Next state and frame boundary strobes
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    unique case (state)
      S_SYNC:   if (cam_vsync) state_nxt = S_VBLANK;
      S_VBLANK: if (!cam_vsync) begin
                  state_nxt   = S_FRAME;
                  frame_start = 1'b1;
                end
      S_FRAME:  if (cam_vsync) begin
                  state_nxt = S_VBLANK;
                  frame_end = 1'b1;
                end
      default:  state_nxt = S_SYNC;
    endcase
  end

  // Byte qualification and window test; a borrow out of x_rel/y_rel means left of / above the window
  always_comb begin
    x_rel     = {1'b0, x} - {1'b0, X_LO};
    y_rel     = {1'b0, y} - {1'b0, Y_LO};
    win_hit   = !x_rel[XW] && (x_rel[XW-1:0] < X_SPAN) && ((x_rel[XW-1:0] & X_MASK) == '0) &&
                !y_rel[YW] && (y_rel[YW-1:0] < Y_SPAN) && ((y_rel[YW-1:0] & Y_MASK) == '0);
    href_rise = cam_href && !href_q;
    href_fall = !cam_href && href_q;
    x_over    = (x == X_END);
    line_ok   = (y != Y_END);
    take_byte = (state == S_FRAME) && !cam_vsync && cam_href && line_ok && !x_over;
  end

  // Capture datapath: byte pairing, line/frame counters, write issue and sticky status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x            <= '0;
      y            <= '0;
      phase        <= 1'b0;
      hi_byte      <= 8'h00;
      href_q       <= 1'b0;
      frozen_q     <= 1'b0;
      overrun      <= 1'b0;
      addr_cnt     <= '0;
      s1_en        <= 1'b0;
      s1_addr      <= '0;
      s1_data      <= 16'h0000;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 8'h00;
      err_line_q   <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      href_q       <= cam_href;
      s1_en        <= 1'b0;
      frame_done_q <= 1'b0;
      if (err_clr) begin
        err_line_q  <= 1'b0;
        err_frame_q <= 1'b0;
      end
      if (frame_start) begin
        frozen_q <= freeze;
        x        <= '0;
        y        <= '0;
        phase    <= 1'b0;
        overrun  <= 1'b0;
        addr_cnt <= '0;
      end
      if (frame_end) begin
        frame_done_q <= 1'b1;
        frame_cnt_q  <= frame_cnt_q + 8'd1;
        phase        <= 1'b0;
      end
      if (state == S_FRAME && !cam_vsync) begin
        // y saturates at FRAME_H so every extra line is dropped rather than wrapping
        if (href_fall) begin
          x       <= '0;
          phase   <= 1'b0;
          overrun <= 1'b0;
          if (line_ok) y <= y + 1'b1;
        end
        if (href_rise && !line_ok) err_frame_q <= 1'b1;
        if (cam_href && line_ok && x_over && !overrun) begin
          err_line_q <= 1'b1;
          overrun    <= 1'b1;
        end
        if (take_byte) begin
          if (!phase) begin
            hi_byte <= cam_data;
            phase   <= 1'b1;
          end else begin
            phase <= 1'b0;
            x     <= x + 1'b1;
            if (win_hit && !frozen_q) begin
              s1_en    <= 1'b1;
              s1_addr  <= addr_cnt;
              s1_data  <= {hi_byte, cam_data};
              addr_cnt <= addr_cnt + 1'b1;
            end
          end
        end
      end
    end
  end

`ifdef GRAY_OUT_EN
  logic [7:0]        r8, g8, b8;
  logic [15:0]       luma;
  logic              g_en;
  logic [ADDR_W-1:0] g_addr;
  logic [15:0]       g_data;

  // RGB565 widened to 8 bits per channel by replication, then weighted luma
  always_comb begin
    r8   = {s1_data[15:11], s1_data[15:13]};
    g8   = {s1_data[10:5],  s1_data[10:9]};
    b8   = {s1_data[4:0],   s1_data[4:2]};
    luma = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
  end

  // Second write stage carrying the grey pixel; address/data hold between writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g_en   <= 1'b0;
      g_addr <= '0;
      g_data <= 16'h0000;
    end else begin
      g_en <= s1_en;
      if (s1_en) begin
        g_addr <= s1_addr;
        g_data <= luma >> 8;
      end
    end
  end

  assign wr_en   = g_en;
  assign wr_addr = g_addr;
  assign wr_data = g_data;
`else
  assign wr_en   = s1_en;
  assign wr_addr = s1_addr;
  assign wr_data = s1_data;
`endif

  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = (state == S_FRAME);
  assign err_line   = err_line_q;
  assign err_frame  = err_frame_q;

endmodule

// File: tb/tb_cam_window_capture.sv
// tb/tb_cam_window_capture.sv - self-checking bench for cam_window_capture
`timescale 1ns/1ps
module tb_cam_window_capture;
  localparam int FW = 20, FH = 12, X0 = 3, Y0 = 2, WW = 8, WH = 6, D = 2, AW = 4;
`ifdef GRAY_OUT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cam_vsync = 1'b0, cam_href = 1'b0, freeze = 1'b0, err_clr = 1'b0;
  logic [7:0]    cam_data = 8'h00;
  logic          wr_en, frame_done, busy, err_line, err_frame;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [7:0]    frame_cnt;

  int total = 0, bad = 0, cyc = 0;
  int wr_seen = 0, wr_exp = 0, fd_seen = 0, fd_exp = 0, cnt_exp = 0;
  bit live = 0, cur_frozen = 0, exp_el = 0, exp_ef = 0;

  typedef struct {int addr; int data; int at;} wr_t;
  wr_t exp_q[$];

  typedef struct {logic [15:0] pix; bit hit; int addr; logic [15:0] raw; logic [15:0] gray;} vec_t;
  vec_t tv[12];

  cam_window_capture #(
    .FRAME_W(FW), .FRAME_H(FH), .WIN_X0(X0), .WIN_Y0(Y0),
    .WIN_W(WW), .WIN_H(WH), .DECIM(D), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .freeze(freeze), .err_clr(err_clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy),
    .err_line(err_line), .err_frame(err_frame)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard: every write must match the oldest expected write, including its arrival cycle
  always @(negedge clk) begin : mon
    wr_t e;
    if (frame_done === 1'b1) fd_seen++;
    if (wr_en === 1'b1) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h expected none (cycle %0d)", wr_addr, wr_data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", 32'(wr_data), 32'(e.data));
        check("wr_latency", 32'(cyc), 32'(e.at));
      end
    end
  end

  function automatic logic [15:0] exp_pix(input logic [15:0] p);
`ifdef GRAY_OUT_EN
    int r, g, b;
    r = int'(p[15:11]);
    g = int'(p[10:5]);
    b = int'(p[4:0]);
    r = r * 8 + r / 4;
    g = g * 4 + g / 16;
    b = b * 8 + b / 4;
    return 16'((77 * r + 150 * g + 29 * b) / 256);
`else
    return p;
`endif
  endfunction

  function automatic bit in_win(input int x, input int y);
    return x >= X0 && x < X0 + WW && y >= Y0 && y < Y0 + WH && (x - X0) % D == 0 && (y - Y0) % D == 0;
  endfunction

  function automatic int rand_len();
    return ($urandom_range(7, 0) == 0) ? FW + 1 : int'($urandom_range(FW, FW - 3));
  endfunction

  task automatic drive(input logic v, input logic h, input logic [7:0] d);
    cam_vsync = v;
    cam_href  = h;
    cam_data  = d;
    @(negedge clk);
  endtask

  task automatic send_pixel(input logic [15:0] p, input bit push, input int addr, input logic [15:0] edata);
    wr_t e;
    drive(1'b0, 1'b1, p[15:8]);
    err_clr = 1'b0;
    if (push) begin
      e.addr = addr;
      e.data = int'(edata);
      e.at   = cyc + LAT;
      exp_q.push_back(e);
      wr_exp++;
    end
    drive(1'b0, 1'b1, p[7:0]);
  endtask

  task automatic send_line(input int y, input int n, input bit orphan, input int clr_byte);
    logic [15:0] p;
    bit ok;
    for (int x = 0; x < n; x++) begin
      p = 16'($urandom);
      err_clr = (2 * x == clr_byte);
      ok = live && !cur_frozen && x < FW && y < FH && in_win(x, y);
      send_pixel(p, ok, ((y - Y0) / D) * (WW / D) + (x - X0) / D, exp_pix(p));
    end
    if (orphan) drive(1'b0, 1'b1, 8'h5a);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    if (live && clr_byte >= 0 && clr_byte < 2 * n) begin
      exp_el = 0;
      exp_ef = 0;
    end
    if (live && y < FH && 2 * n + int'(orphan) > 2 * FW) exp_el = 1;
    if (live && y >= FH && (n > 0 || orphan)) exp_ef = 1;
  endtask

  task automatic frame_begin(input bit frz);
    freeze = frz;
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    cur_frozen = frz;
    live = 1;
    drive(1'b0, 1'b0, 8'h00);
    check("busy_in_frame", 32'(busy), 32'd1);
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame_end_chk();
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    fd_exp++;
    cnt_exp = (cnt_exp + 1) % 256;
    check("frame_done_pulses", 32'(fd_seen), 32'(fd_exp));
    check("frame_cnt", 32'(frame_cnt), 32'(cnt_exp));
    check("busy_after_frame", 32'(busy), 32'd0);
    check("err_line", 32'(err_line), 32'(exp_el));
    check("err_frame", 32'(err_frame), 32'(exp_ef));
    check("writes_total", 32'(wr_seen), 32'(wr_exp));
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic full_frame(input bit frz, input bit frz_mid, input int nlines);
    frame_begin(frz);
    for (int y = 0; y < nlines; y++) begin
      if (y == nlines / 2) freeze = frz_mid;
      send_line(y, rand_len(), 1'($urandom_range(1, 0)), -1);
    end
    frame_end_chk();
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    drive(cam_vsync, 1'b0, 8'h00);
    err_clr = 1'b0;
    drive(cam_vsync, 1'b0, 8'h00);
    exp_el = 0;
    exp_ef = 0;
    check("err_line_clr", 32'(err_line), 32'd0);
    check("err_frame_clr", 32'(err_frame), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    // Line 2 is the first window row; hits at x = 3, 5, 7, 9
    tv[0]  = '{16'h1111, 0, 0, 16'h1111, 16'h0000};
    tv[1]  = '{16'h2222, 0, 0, 16'h2222, 16'h0000};
    tv[2]  = '{16'h3333, 0, 0, 16'h3333, 16'h0000};
    tv[3]  = '{16'hFFFF, 1, 0, 16'hFFFF, 16'h00FF};
    tv[4]  = '{16'h4444, 0, 0, 16'h4444, 16'h0000};
    tv[5]  = '{16'h0000, 1, 1, 16'h0000, 16'h0000};
    tv[6]  = '{16'h5555, 0, 0, 16'h5555, 16'h0000};
    tv[7]  = '{16'hF800, 1, 2, 16'hF800, 16'h004C};
    tv[8]  = '{16'h6666, 0, 0, 16'h6666, 16'h0000};
    tv[9]  = '{16'h07E0, 1, 3, 16'h07E0, 16'h0095};
    tv[10] = '{16'h7777, 0, 0, 16'h7777, 16'h0000};
    tv[11] = '{16'h001F, 0, 0, 16'h001F, 16'h0000};

    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_line", 32'(err_line), 32'd0);
    check("rst_err_frame", 32'(err_frame), 32'd0);
    rst_n = 1'b1;

    // Lines before any VSYNC are not captured
    for (int y = 0; y < 4; y++) send_line(y, FW, 1'b0, -1);
    check("no_write_before_sync", 32'(wr_seen), 32'd0);

    // Table-driven window row
    frame_begin(1'b0);
    send_line(0, FW, 1'b0, -1);
    send_line(1, FW, 1'b0, -1);
    for (int i = 0; i < 12; i++) begin
`ifdef GRAY_OUT_EN
      send_pixel(tv[i].pix, tv[i].hit, tv[i].addr, tv[i].gray);
`else
      send_pixel(tv[i].pix, tv[i].hit, tv[i].addr, tv[i].raw);
`endif
    end
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    frame_end_chk();

    // Random frames against the model
    for (int f = 0; f < 4; f++) full_frame(1'b0, 1'b0, int'($urandom_range(FH + 1, FH - 1)));
    pulse_clr();

    // Freeze sampled at frame start only
    full_frame(1'b0, 1'b1, FH);
    w0 = wr_seen;
    full_frame(1'b1, 1'b0, FH);
    check("frozen_frame_writes", 32'(wr_seen - w0), 32'd0);
    w0 = wr_seen;
    full_frame(1'b0, 1'b0, FH);
    check("resumed_frame_has_writes", 32'(wr_seen - w0 > 0), 32'd1);
    pulse_clr();

    // Line overrun, clear, then clear coincident with a new overrun
    frame_begin(1'b0);
    send_line(0, FW + 3, 1'b0, -1);
    check("err_line_set", 32'(err_line), 32'd1);
    pulse_clr();
    send_line(1, FW, 1'b0, -1);
    send_line(2, FW + 3, 1'b0, -1);
    check("err_line_set_win_row", 32'(err_line), 32'd1);
    pulse_clr();
    send_line(3, FW + 1, 1'b0, 2 * FW);
    check("err_line_set_beats_clr", 32'(err_line), 32'd1);
    for (int y = 4; y < FH; y++) send_line(y, FW, 1'b0, -1);
    frame_end_chk();
    pulse_clr();

    // Too many lines
    frame_begin(1'b0);
    for (int y = 0; y < FH + 2; y++) send_line(y, FW, 1'b0, -1);
    check("err_frame_set", 32'(err_frame), 32'd1);
    frame_end_chk();
    pulse_clr();

    // VSYNC rises with a window pixel half received
    frame_begin(1'b0);
    send_line(0, FW, 1'b0, -1);
    send_line(1, FW, 1'b0, -1);
    for (int x = 0; x < 3; x++) send_pixel(16'hABCD, 1'b0, 0, 16'h0000);
    drive(1'b0, 1'b1, 8'hEE);
    frame_end_chk();

    // Reset mid-frame, then lines without a full VSYNC cycle
    frame_begin(1'b0);
    send_line(0, FW, 1'b0, -1);
    drive(1'b0, 1'b1, 8'h12);
    drive(1'b0, 1'b1, 8'h34);
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 8'h56);
    rst_n = 1'b1;
    live = 0;
    cnt_exp = 0;
    exp_el = 0;
    exp_ef = 0;
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_wr_addr", 32'(wr_addr), 32'd0);
    check("midrst_wr_data", 32'(wr_data), 32'd0);
    check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_err_line", 32'(err_line), 32'd0);
    check("midrst_err_frame", 32'(err_frame), 32'd0);
    w0 = wr_seen;
    for (int y = 1; y < FH; y++) send_line(y, FW, 1'b0, -1);
    check("no_write_after_midrst", 32'(wr_seen - w0), 32'd0);
    full_frame(1'b0, 1'b0, FH);

    // Frame counter wraps 255 -> 0
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 8'h00);
      fd_exp++;
    end
    drive(1'b1, 1'b0, 8'h00);
    check("frame_cnt_wrap", 32'(frame_cnt), 32'(cnt_exp));
    check("frame_done_wrap_pulses", 32'(fd_seen), 32'(fd_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
